// File: rtl/dffe_ctl_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : dffe_ctl_seq_if
// Brief    : Control/status bundle between a requester and dffe_ctl_seq.
// Revision : 1.0 - initial release
// ============================================================================
interface dffe_ctl_seq_if #(
    parameter int DIV_W = 8
);
    logic             start;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] count;
    logic             abort;
    logic             ena;
    logic             rsn;
    logic             prn;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, mode, div, count, abort,
        input  ena, rsn, prn, busy, done, err
    );

    modport slave (
        input  start, mode, div, count, abort,
        output ena, rsn, prn, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/dffe_ctl_seq.sv
`default_nettype none
// ============================================================================
// Module   : dffe_ctl_seq
// Brief    : Clear/preset phase followed by a programmed train of enable pulses.
// Revision : 1.0 - initial release
// ============================================================================
module dffe_ctl_seq #(
    parameter int HOLD_CYC = 2,
    parameter int DIV_W    = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    dffe_ctl_seq_if.slave      bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ASSERT = 3'd1,
        S_GAP    = 3'd2,
        S_LOAD   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [1:0]       c_MODE_LOAD = 2'b00;
    localparam logic [1:0]       c_MODE_CLR  = 2'b01;
    localparam logic [1:0]       c_MODE_PRE  = 2'b10;
    localparam logic [1:0]       c_MODE_RSV  = 2'b11;
    localparam logic [3:0]       c_HOLD_LAST = 4'(HOLD_CYC - 1);
    localparam logic [DIV_W-1:0] c_ZERO      = '0;
    localparam logic [DIV_W-1:0] c_ONE       = DIV_W'(1);

    state_t           r_state, w_state_nx;
    logic             r_go, w_go_nx;
    logic             r_rej, w_rej_nx;
    logic [1:0]       r_mode, w_mode_nx;
    logic [DIV_W-1:0] r_div, w_div_nx;
    logic [DIV_W-1:0] r_cnt, w_cnt_nx;
    logic [DIV_W-1:0] r_dcnt, w_dcnt_nx;
    logic [3:0]       r_hcnt, w_hcnt_nx;

    logic r_ena, r_rsn, r_prn, r_busy, r_done, r_err;
    logic w_ena_nx, w_rsn_nx, w_prn_nx, w_busy_nx, w_done_nx, w_err_nx;

    // A start accepted in IDLE only arms r_go; the sequence itself begins on the
    // following edge, so every output phase starts one cycle after the request.
    always_comb begin
        w_state_nx = r_state;
        w_go_nx    = 1'b0;
        w_rej_nx   = 1'b0;
        w_mode_nx  = r_mode;
        w_div_nx   = r_div;
        w_cnt_nx   = r_cnt;
        w_dcnt_nx  = r_dcnt;
        w_hcnt_nx  = r_hcnt;

        if (bus.abort) begin
            w_state_nx = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_go) begin
                        if (r_mode == c_MODE_LOAD) begin
                            w_dcnt_nx  = c_ZERO;
                            w_state_nx = (r_cnt == c_ZERO) ? S_DONE : S_LOAD;
                        end else begin
                            w_hcnt_nx  = 4'd0;
                            w_state_nx = S_ASSERT;
                        end
                    end else if (bus.start) begin
                        if (bus.mode == c_MODE_RSV) begin
                            w_rej_nx = 1'b1;
                        end else begin
                            w_go_nx   = 1'b1;
                            w_mode_nx = bus.mode;
                            w_div_nx  = bus.div;
                            w_cnt_nx  = bus.count;
                        end
                    end
                end
                S_ASSERT: begin
                    if (r_hcnt == c_HOLD_LAST) begin
                        w_state_nx = S_GAP;
                    end else begin
                        w_hcnt_nx = r_hcnt + 4'd1;
                    end
                end
                S_GAP: begin
                    w_dcnt_nx  = c_ZERO;
                    w_state_nx = (r_cnt == c_ZERO) ? S_DONE : S_LOAD;
                end
                S_LOAD: begin
                    // r_cnt counts remaining pulses down, so it cannot wrap.
                    if (r_dcnt == r_div) begin
                        w_dcnt_nx = c_ZERO;
                        w_cnt_nx  = r_cnt - c_ONE;
                        if (r_cnt == c_ONE) begin
                            w_state_nx = S_DONE;
                        end
                    end else begin
                        w_dcnt_nx = r_dcnt + c_ONE;
                    end
                end
                S_DONE: begin
                    w_state_nx = S_IDLE;
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end

        w_ena_nx  = (w_state_nx == S_LOAD) && (w_dcnt_nx == r_div);
        w_rsn_nx  = !((w_state_nx == S_ASSERT) && (r_mode == c_MODE_CLR));
        w_prn_nx  = !((w_state_nx == S_ASSERT) && (r_mode == c_MODE_PRE));
        w_busy_nx = (w_state_nx != S_IDLE);
        w_done_nx = (w_state_nx == S_DONE);
        w_err_nx  = r_rej;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_go    <= 1'b0;
            r_rej   <= 1'b0;
            r_mode  <= 2'b00;
            r_div   <= c_ZERO;
            r_cnt   <= c_ZERO;
            r_dcnt  <= c_ZERO;
            r_hcnt  <= 4'd0;
            r_ena   <= 1'b0;
            r_rsn   <= 1'b1;
            r_prn   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_go    <= w_go_nx;
            r_rej   <= w_rej_nx;
            r_mode  <= w_mode_nx;
            r_div   <= w_div_nx;
            r_cnt   <= w_cnt_nx;
            r_dcnt  <= w_dcnt_nx;
            r_hcnt  <= w_hcnt_nx;
            r_ena   <= w_ena_nx;
            r_rsn   <= w_rsn_nx;
            r_prn   <= w_prn_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_err   <= w_err_nx;
        end
    end

    assign bus.ena  = r_ena;
    assign bus.rsn  = r_rsn;
    assign bus.prn  = r_prn;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.err  = r_err;
endmodule
`default_nettype wire

// File: doc/dffe_ctl_seq.md
DFFE_CTL_SEQ -- requirements
Module: dffe_ctl_seq

Upstream control sequencer for a bank of enable flops. It drives their ena, rsn and prn inputs: an optional clear or preset phase, then a programmed train of enable pulses.

Interface
REQ-001 The block SHALL have parameter HOLD_CYC, default 2: the number of cycles rsn/prn is held low (legal range 1..15).
REQ-002 The block SHALL have parameter DIV_W, default 8: the width of div and count.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port start, input, 1 bit: request to begin a sequence, sampled in IDLE only.
REQ-006 Port mode, input, 2 bits: sequence type. 00 = load only, 01 = clear then load, 10 = preset then load, 11 = reserved.
REQ-007 Port div, input, DIV_W bits: the enable period minus 1; ena fires once every div+1 cycles.
REQ-008 Port count, input, DIV_W bits: the number of ena pulses to issue.
REQ-009 Port abort, input, 1 bit: synchronous cancel, effective in any state.
REQ-010 Port ena, output, 1 bit: enable to the downstream flops, active-high.
REQ-011 Port rsn, output, 1 bit: reset to the downstream flops, active-low.
REQ-012 Port prn, output, 1 bit: preset to the downstream flops, active-low.
REQ-013 Port busy, output, 1 bit: high while a sequence is in progress.
REQ-014 Port done, output, 1 bit: one-cycle completion pulse.
REQ-015 Port err, output, 1 bit: one-cycle pulse when a start with a reserved mode is rejected.

Function
REQ-016 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.
REQ-017 The FSM SHALL have states IDLE, ASSERT, GAP, LOAD and DONE.
REQ-018 In IDLE, start=1 with mode 00/01/10 SHALL capture mode, div and count into internal registers; later input changes SHALL NOT affect the running sequence.
REQ-019 Timing reference: start is sampled at edge k.
REQ-020 For mode 01, rsn SHALL be low for exactly HOLD_CYC cycles beginning at edge k+1; prn SHALL stay high.
REQ-021 For mode 10, prn SHALL be low for exactly HOLD_CYC cycles beginning at edge k+1; rsn SHALL stay high.
REQ-022 rsn and prn SHALL never be low in the same cycle.
REQ-023 After ASSERT, the FSM SHALL spend exactly one GAP cycle with rsn=prn=1 and ena=0 before entering LOAD.
REQ-024 Mode 00 SHALL skip ASSERT and GAP and enter LOAD at edge k+1.
REQ-025 Let L be the edge on which LOAD is entered. Pulse i (i = 0..count-1) SHALL occupy the single cycle starting at edge L+div+i*(div+1).
REQ-026 ena SHALL be high only during those pulse cycles.
REQ-027 div=0 SHALL give ena high on count consecutive cycles.
REQ-028 The divider counter SHALL reset to 0 on LOAD entry and after each pulse.
REQ-029 The pulse counter SHALL be DIV_W bits wide and SHALL never wrap; count = 2^DIV_W-1 is legal.
REQ-030 count=0 SHALL issue no ena pulse; the FSM SHALL go straight to DONE at the edge it would otherwise enter LOAD.
REQ-031 DONE SHALL last one cycle, beginning at the edge after the last ena cycle ends.
REQ-032 done SHALL be high only in DONE; the FSM SHALL then return to IDLE.
REQ-033 busy SHALL be high from edge k+1 through the DONE cycle inclusive, and low otherwise.
REQ-034 start SHALL be ignored while busy=1.
REQ-035 A start asserted in the DONE cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.
REQ-036 start=1 with mode=11 in IDLE SHALL raise err high for one cycle starting at edge k+1, and the FSM SHALL stay in IDLE with busy=0.
REQ-037 abort=1 at any edge in a non-IDLE state SHALL return the FSM to IDLE at that edge with ena=0, rsn=1, prn=1, busy=0 and no done pulse.
REQ-038 abort SHALL take priority over start and over state progression.
REQ-039 abort in IDLE SHALL have no effect, and SHALL also block a simultaneous start.

Reset
REQ-040 rst=1 sampled at an edge SHALL force IDLE and clear all counters and captured registers.
REQ-041 rst SHALL force outputs to ena=0, rsn=1, prn=1, busy=0, done=0, err=0.
REQ-042 rst SHALL take priority over abort and start.
REQ-043 Reset mid-sequence SHALL truncate it immediately: no done pulse, and any rsn/prn low phase ends.
REQ-044 Outputs SHALL hold their reset values for every cycle in which rst=1.

Verification
REQ-045 Mode 00, div=0, count=3, start at edge 10 -> ena high cycles 11,12,13; done at 14; busy 11..14.
REQ-046 Mode 01, HOLD_CYC=2, div=2, count=2, start at edge 0 -> rsn low cycles 1-2; gap 3; ena at 6 and 9; done at 10; prn always 1.
REQ-047 Mode 10, count=0, start at edge 0 -> prn low cycles 1-2; gap 3; done at 4; ena never high.
REQ-048 Mode 11 start -> err pulse for one cycle, busy stays 0; a second start at the next edge with mode 00 proceeds normally.
REQ-049 Mode 01 with abort during rsn low -> rsn=1 and busy=0 on the abort edge; no done. Repeat with rst instead of abort -> same result.
REQ-050 Assertions run on all tests: never rsn=prn=0; done implies busy; ena only in LOAD; start while busy has no effect.
